// File: rtl/demux_1xn_stream_pkg.sv
// Shared types and default widths for the 1xN stream demultiplexer.
package demux_pkg;

  typedef enum logic {
    MODE_ROUTE = 1'b0,
    MODE_BCAST = 1'b1
  } mode_e;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_NUM_OUT = 4;
  localparam int unsigned DEF_CNT_W   = 16;

endpackage

// File: rtl/demux_1xn_stream_if.sv
// Producer/consumer bundle for demux_1xn_stream. SEL_W is derived from NUM_OUT.
interface demux_1xn_stream_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned SEL_W = $clog2(NUM_OUT);

  logic [DATA_W-1:0]         in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      bcast;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;
  logic [CNT_W-1:0]          drop_cnt;
  logic                      sel_err;

  // Environment side: producer inputs and consumer ready.
  modport master (
    output in_data, in_valid, sel, bcast, out_ready,
    input  in_ready, out_data, out_valid, drop_cnt, sel_err
  );

  // Demux side.
  modport slave (
    input  in_data, in_valid, sel, bcast, out_ready,
    output in_ready, out_data, out_valid, drop_cnt, sel_err
  );
endinterface

// File: rtl/demux_1xn_stream_slot.sv
// One-entry holding slot for a single output channel.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              drain,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next state: a load wins over a drain, so load+drain keeps the slot full with the new word.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = S_FULL;
      data_d  = din;
    end else if (state_q == S_FULL && drain) begin
      state_d = S_EMPTY;
    end
  end

  // Slot registers; data is kept after draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == S_FULL);
  assign dout  = data_q;

endmodule

// File: rtl/demux_1xn_stream.sv
// 1xN valid/ready demultiplexer with routed, broadcast and drop paths.
module demux_1xn_stream
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned NUM_OUT = DEF_NUM_OUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  demux_1xn_stream_if.slave   bus
);

  localparam int unsigned SEL_W = $clog2(NUM_OUT);

  logic [NUM_OUT-1:0]        sel_hit;
  logic                      sel_in_range;
  logic [NUM_OUT-1:0]        can_take;
  logic [NUM_OUT-1:0]        load;
  logic                      in_ready_c;
  logic                      drop;
  logic [NUM_OUT-1:0]        out_valid_w;
  logic [NUM_OUT*DATA_W-1:0] out_data_w;
  logic [CNT_W-1:0]          drop_cnt_q, drop_cnt_d;
  logic                      sel_err_q, sel_err_d;
  mode_e                     mode;

  assign mode     = mode_e'(bus.bcast);
  assign can_take = ~out_valid_w | bus.out_ready;

  // One-hot select decode; an empty decode means sel is out of range.
  always_comb begin
    sel_hit = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      sel_hit[i] = (bus.sel == SEL_W'(i));
    end
    sel_in_range = |sel_hit;
  end

  // Ready/load/drop decisions; broadcast only proceeds when every slot can take.
  always_comb begin
    in_ready_c = 1'b0;
    load       = '0;
    drop       = 1'b0;
    if (mode == MODE_BCAST) begin
      in_ready_c = &can_take;
      load       = {NUM_OUT{bus.in_valid & in_ready_c}};
    end else if (sel_in_range) begin
      in_ready_c = |(sel_hit & can_take);
      load       = sel_hit & {NUM_OUT{bus.in_valid & in_ready_c}};
    end else begin
      in_ready_c = 1'b1;
      drop       = bus.in_valid;
    end
  end

  // Saturating drop counter and one-cycle error pulse.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
    sel_err_d = drop;
  end

  // Drop counter and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      sel_err_q  <= sel_err_d;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[g]),
      .din   (bus.in_data),
      .drain (bus.out_ready[g]),
      .valid (out_valid_w[g]),
      .dout  (out_data_w[g*DATA_W +: DATA_W])
    );
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_data_w;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Directed bench for demux_1xn_stream: a 4-channel instance and a 3-channel
// instance (narrow counter) for the out-of-range/saturation path.
module tb_demux_1xn_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_1xn_stream_if #(.DATA_W(8), .NUM_OUT(4), .CNT_W(16)) if4 ();
  demux_1xn_stream_if #(.DATA_W(8), .NUM_OUT(3), .CNT_W(4))  if3 ();

  demux_1xn_stream #(.DATA_W(8), .NUM_OUT(4), .CNT_W(16)) u_dut4 (
    .clk (clk), .rst (rst), .bus (if4)
  );
  demux_1xn_stream #(.DATA_W(8), .NUM_OUT(3), .CNT_W(4)) u_dut3 (
    .clk (clk), .rst (rst), .bus (if3)
  );

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  sel;
    logic        bcast;
    logic        valid;
    logic [3:0]  oready;
    logic        exp_rdy;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic [1:0] s, input logic b,
                              input logic v, input logic [3:0] r, input logic er,
                              input logic [3:0] ev, input logic [31:0] ed);
    vec_t t;
    t.data = d; t.sel = s; t.bcast = b; t.valid = v; t.oready = r;
    t.exp_rdy = er; t.exp_valid = ev; t.exp_data = ed;
    return t;
  endfunction

  function automatic logic [31:0] vmask(input logic [3:0] v);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (v[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Watchdog: all stimulus is fixed-length, this only guards against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[4][$];
    logic [7:0] w;
    int rx;

    // ---- stimulus table (4-channel instance, starts from reset) ----
    vecs[0]  = mk(8'hA5, 2'd2, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h00A5_0000);
    vecs[1]  = mk(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h0000_0000);
    vecs[2]  = mk(8'h11, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b1, 4'b0010, 32'h0000_1100);
    vecs[3]  = mk(8'h22, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b0, 4'b0010, 32'h0000_1100);
    vecs[4]  = mk(8'h22, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b0, 4'b0010, 32'h0000_1100);
    vecs[5]  = mk(8'h22, 2'd1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h0000_2200);
    vecs[6]  = mk(8'h00, 2'd1, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h0000_0000);
    vecs[7]  = mk(8'h99, 2'd3, 1'b0, 1'b1, 4'b0111, 1'b1, 4'b1000, 32'h9900_0000);
    vecs[8]  = mk(8'h3C, 2'd0, 1'b1, 1'b1, 4'b0111, 1'b0, 4'b1000, 32'h9900_0000);
    vecs[9]  = mk(8'h3C, 2'd0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111, 32'h3C3C_3C3C);
    vecs[10] = mk(8'h00, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1111, 32'h3C3C_3C3C);
    vecs[11] = mk(8'h55, 2'd0, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b1111, 32'h3C3C_3C55);
    vecs[12] = mk(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h0000_0000);

    if4.in_data = '0; if4.in_valid = 1'b0; if4.sel = '0; if4.bcast = 1'b0; if4.out_ready = '1;
    if3.in_data = '0; if3.in_valid = 1'b0; if3.sel = '0; if3.bcast = 1'b0; if3.out_ready = '1;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid4", 32'(if4.out_valid), 32'h0);
    check("rst_data4", if4.out_data, 32'h0);
    check("rst_cnt4", 32'(if4.drop_cnt), 32'h0);
    check("rst_err4", 32'(if4.sel_err), 32'h0);
    check("rst_cnt3", 32'(if3.drop_cnt), 32'h0);
    rst = 1'b0;

    // ---- table: route, backpressure, broadcast stall ----
    for (int i = 0; i < 13; i++) begin
      if4.in_data = vecs[i].data; if4.sel = vecs[i].sel; if4.bcast = vecs[i].bcast;
      if4.in_valid = vecs[i].valid; if4.out_ready = vecs[i].oready;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(if4.in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d_out_valid", i), 32'(if4.out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_out_data", i), if4.out_data & vmask(vecs[i].exp_valid),
            vecs[i].exp_data);
    end
    if4.in_valid = 1'b0; if4.bcast = 1'b0; if4.out_ready = '1;

    // ---- out-of-range drop on the 3-channel instance ----
    if3.in_data = 8'h77; if3.sel = 2'd3; if3.in_valid = 1'b1; if3.out_ready = 3'b111;
    #1;
    check("drop_in_ready", 32'(if3.in_ready), 32'h1);
    @(posedge clk); #1;
    if3.in_valid = 1'b0;
    check("drop_valid", 32'(if3.out_valid), 32'h0);
    check("drop_err1", 32'(if3.sel_err), 32'h1);
    check("drop_cnt1", 32'(if3.drop_cnt), 32'h1);
    @(posedge clk); #1;
    check("drop_err_off", 32'(if3.sel_err), 32'h0);
    check("drop_cnt_hold", 32'(if3.drop_cnt), 32'h1);
    if3.in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    if3.in_valid = 1'b0;
    check("drop_err_stream", 32'(if3.sel_err), 32'h1);
    check("drop_cnt_sat", 32'(if3.drop_cnt), 32'hF);
    check("drop_valid_after", 32'(if3.out_valid), 32'h0);
    @(posedge clk); #1;
    check("drop_err_end", 32'(if3.sel_err), 32'h0);
    check("drop_cnt_sat_hold", 32'(if3.drop_cnt), 32'hF);
    // in-range word on the 3-channel instance still routes
    if3.in_data = 8'h44; if3.sel = 2'd2; if3.in_valid = 1'b1; if3.out_ready = 3'b000;
    @(posedge clk); #1;
    if3.in_valid = 1'b0;
    check("n3_route_valid", 32'(if3.out_valid), 32'h4);
    check("n3_route_data", 32'(if3.out_data), 32'h0044_0000);
    check("n3_route_err", 32'(if3.sel_err), 32'h0);

    // ---- async reset mid-operation ----
    if4.out_ready = 4'b0000;
    if4.in_data = 8'h01; if4.sel = 2'd0; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_data = 8'h02; if4.sel = 2'd2;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    check("pre_rst_valid", 32'(if4.out_valid), 32'h5);
    #2 rst = 1'b1;
    #1;
    check("arst_valid4", 32'(if4.out_valid), 32'h0);
    check("arst_data4", if4.out_data, 32'h0);
    check("arst_cnt3", 32'(if3.drop_cnt), 32'h0);
    check("arst_valid3", 32'(if3.out_valid), 32'h0);
    #2 rst = 1'b0;
    if4.out_ready = '1; if4.in_data = 8'h5A; if4.sel = 2'd0; if4.in_valid = 1'b1;
    if3.out_ready = '1;
    #1;
    check("post_rst_ready", 32'(if4.in_ready), 32'h1);
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    check("post_rst_valid", 32'(if4.out_valid), 32'h1);
    check("post_rst_data", 32'(if4.out_data[7:0]), 32'h5A);
    @(posedge clk); #1;

    // ---- full-rate sweep with per-channel scoreboard ----
    rx = 0;
    for (int k = 0; k < 101; k++) begin
      if (k < 100) begin
        w = 8'($urandom_range(0, 255));
        if4.in_data = w; if4.sel = 2'(k % 4); if4.in_valid = 1'b1;
        q[k % 4].push_back(w);
        #1;
        check("sweep_in_ready", 32'(if4.in_ready), 32'h1);
      end else begin
        if4.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) begin
        if (if4.out_valid[c]) begin
          rx++;
          if (q[c].size() == 0) begin
            check($sformatf("sweep_extra_ch%0d", c), 32'h1, 32'h0);
          end else begin
            check($sformatf("sweep_ch%0d", c), 32'(if4.out_data[c*8 +: 8]),
                  32'(q[c].pop_front()));
          end
        end
      end
    end
    check("sweep_rx_count", 32'(rx), 32'd100);
    check("sweep_err4", 32'(if4.sel_err), 32'h0);
    check("sweep_cnt4", 32'(if4.drop_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
